// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// controller FSM states and the hardwired-zero register address.
package pipe_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int unsigned REG_ZERO = 0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_fwd_sel.sv
// Per-operand EX forwarding select: a non-load result in MEM beats a WB write,
// and register 0 never forwards.
module pipe_fwd_sel #(
  parameter int REG_AW = 5
) (
  input  logic              en_i,
  input  logic [REG_AW-1:0] src_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_reg_write_i,
  input  logic              mem_mem_read_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              wb_reg_write_i,
  output logic [1:0]        sel_o
);
  import pipe_pkg::*;

  logic mem_hit_s;
  logic wb_hit_s;

  // Priority select between MEM result, WB result and the register file value
  always_comb begin
    mem_hit_s = mem_reg_write_i && !mem_mem_read_i && (src_i == mem_rd_i) &&
                (src_i != REG_AW'(REG_ZERO));
    wb_hit_s  = wb_reg_write_i && (src_i == wb_rd_i) && (src_i != REG_AW'(REG_ZERO));
    sel_o     = FWD_REG;
    if (!en_i) begin
      sel_o = FWD_REG;
    end else if (mem_hit_s) begin
      sel_o = FWD_MEM;
    end else if (wb_hit_s) begin
      sel_o = FWD_WB;
    end else begin
      sel_o = FWD_REG;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, stall and flush controller for the 5-stage pipeline, with a
// multi-cycle EX occupancy FSM and saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int REG_AW    = 5,
  parameter bit FWD_EN    = 1'b1,
  parameter int MULTI_LAT = 4,
  parameter int CNT_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_use_rs_i,
  input  logic              id_use_rt_i,
  input  logic              id_branch_i,
  input  logic              id_taken_i,
  input  logic              id_jump_i,
  input  logic              id_multi_i,
  input  logic [REG_AW-1:0] ex_rs_i,
  input  logic [REG_AW-1:0] ex_rt_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_reg_write_i,
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_reg_write_i,
  input  logic              mem_mem_read_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              wb_reg_write_i,
  output logic              pc_en_o,
  output logic              if_id_en_o,
  output logic              if_id_flush_o,
  output logic              id_ex_en_o,
  output logic              id_ex_bubble_o,
  output logic              ex_mem_bubble_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              id_fwd_a_o,
  output logic              id_fwd_b_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);
  import pipe_pkg::*;

  localparam int CW = (MULTI_LAT > 2) ? $clog2(MULTI_LAT) : 1;
  localparam logic [CW-1:0] LAT_LOAD = CW'(MULTI_LAT - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             started_q, started_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic ex_fwd_en_s, rs_ex_s, rt_ex_s, rs_mem_s, rt_mem_s;
  logic load_use_s, br_haz_s, raw_s, stall_s, flush_s, busy_s;

  function automatic logic reg_match(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
    return (a == b) && (a != REG_AW'(REG_ZERO));
  endfunction

  assign ex_fwd_en_s = started_q && FWD_EN;

  pipe_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .en_i(ex_fwd_en_s), .src_i(ex_rs_i),
    .mem_rd_i(mem_rd_i), .mem_reg_write_i(mem_reg_write_i), .mem_mem_read_i(mem_mem_read_i),
    .wb_rd_i(wb_rd_i), .wb_reg_write_i(wb_reg_write_i), .sel_o(fwd_a_o)
  );

  pipe_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .en_i(ex_fwd_en_s), .src_i(ex_rt_i),
    .mem_rd_i(mem_rd_i), .mem_reg_write_i(mem_reg_write_i), .mem_mem_read_i(mem_mem_read_i),
    .wb_rd_i(wb_rd_i), .wb_reg_write_i(wb_reg_write_i), .sel_o(fwd_b_o)
  );

  // Hazard detection against the sources actually read by the ID instruction
  always_comb begin
    rs_ex_s    = id_use_rs_i && reg_match(ex_rd_i, id_rs_i);
    rt_ex_s    = id_use_rt_i && reg_match(ex_rd_i, id_rt_i);
    rs_mem_s   = id_use_rs_i && reg_match(mem_rd_i, id_rs_i);
    rt_mem_s   = id_use_rt_i && reg_match(mem_rd_i, id_rt_i);
    load_use_s = ex_mem_read_i && (rs_ex_s || rt_ex_s);
    br_haz_s   = id_branch_i && ((ex_reg_write_i && (rs_ex_s || rt_ex_s)) ||
                                 (mem_mem_read_i && (rs_mem_s || rt_mem_s)));
    raw_s      = !FWD_EN && ((ex_reg_write_i && (rs_ex_s || rt_ex_s)) ||
                             (mem_reg_write_i && (rs_mem_s || rt_mem_s)));
    stall_s    = load_use_s || br_haz_s || raw_s;
    busy_s     = (state_q == ST_BUSY);
    flush_s    = !stall_s && !busy_s && (id_jump_i || (id_branch_i && id_taken_i));
    id_fwd_a_o = ex_fwd_en_s && id_branch_i && mem_reg_write_i && !mem_mem_read_i &&
                 reg_match(mem_rd_i, id_rs_i);
    id_fwd_b_o = ex_fwd_en_s && id_branch_i && mem_reg_write_i && !mem_mem_read_i &&
                 reg_match(mem_rd_i, id_rt_i);
  end

  // Pipeline-register controls in priority order: not started, busy, stall, run
  always_comb begin
    pc_en_o         = 1'b0;
    if_id_en_o      = 1'b0;
    if_id_flush_o   = 1'b0;
    id_ex_en_o      = 1'b0;
    id_ex_bubble_o  = 1'b1;
    ex_mem_bubble_o = 1'b0;
    if (!started_q) begin
      id_ex_bubble_o = 1'b1;
    end else if (busy_s) begin
      id_ex_bubble_o  = 1'b0;
      ex_mem_bubble_o = 1'b1;
    end else if (stall_s) begin
      id_ex_en_o     = 1'b1;
      id_ex_bubble_o = 1'b1;
    end else begin
      pc_en_o        = 1'b1;
      if_id_en_o     = 1'b1;
      id_ex_en_o     = 1'b1;
      id_ex_bubble_o = 1'b0;
      if_id_flush_o  = flush_s;
    end
  end

  // Next state for start latch, multi-cycle FSM and saturating counters
  always_comb begin
    started_d   = started_q || start_i;
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (started_q && id_multi_i && !stall_s) begin
          state_d = ST_BUSY;
          cnt_d   = LAT_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_q == {CW{1'b0}}) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
    if (started_q && !pc_en_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (if_id_flush_o && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // State registers; reset aborts any multi-cycle op immediately
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      started_q   <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= {CW{1'b0}};
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      started_q   <= started_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign busy_o      = busy_s;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule
